// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with stall/flush, MEM-stage forwarding info, and the halt
// sequencer that drains older instructions before a single data-memory dump request.
module ex_mem_pipe #(
    parameter int DW           = 16,
    parameter int RW           = 3,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] ALU_in,
    input  logic [DW-1:0] wdata_in,
    input  logic [DW-1:0] PC_in,
    input  logic          MemWrt_in,
    input  logic          readEn_in,
    input  logic          RegWrt_in,
    input  logic [RW-1:0] WrReg_in,
    input  logic          halt_in,
    input  logic          valid_in,
    input  logic          stall,
    input  logic          flush,
    output logic [DW-1:0] ALU,
    output logic [DW-1:0] writeData,
    output logic [DW-1:0] PC,
    output logic          MemWrt,
    output logic          readEn,
    output logic          RegWrt,
    output logic [RW-1:0] WrReg,
    output logic          valid,
    output logic          fwd_valid,
    output logic          load_hazard,
    output logic [RW-1:0] fwd_reg,
    output logic [DW-1:0] fwd_data,
    output logic          halt_stall,
    output logic          dump_req,
    output logic          halted,
    output logic [1:0]    dbg_state
);

    localparam int CW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] CNT_INIT = (DRAIN_CYCLES > 0) ? CW'(DRAIN_CYCLES - 1) : '0;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DUMP, S_HALTED} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pipe_load, pipe_bubble;

    logic [DW-1:0] alu_q, wdata_q, pc_q;
    logic [RW-1:0] wrreg_q;
    logic          memwrt_q, readen_q, regwrt_q, valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Only RUN honours stall/flush; every other state forces bubbles into MEM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pipe_load   = 1'b0;
        pipe_bubble = 1'b0;
        case (state_q)
            S_RUN: begin
                if (flush) begin
                    pipe_bubble = 1'b1;
                end else if (!stall) begin
                    pipe_load = 1'b1;
                    if (valid_in && halt_in) begin
                        cnt_d = CNT_INIT;
                        if (DRAIN_CYCLES == 0) state_d = S_DUMP;
                        else                   state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                pipe_bubble = 1'b1;
                if (cnt_q == '0) state_d = S_DUMP;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_DUMP: begin
                pipe_bubble = 1'b1;
                state_d     = S_HALTED;
            end
            S_HALTED: pipe_bubble = 1'b1;
            default:  state_d     = S_RUN;
        endcase
    end

    // Bubbles clear only control bits; data registers keep their last contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_q    <= '0;
            wdata_q  <= '0;
            pc_q     <= '0;
            wrreg_q  <= '0;
            memwrt_q <= 1'b0;
            readen_q <= 1'b0;
            regwrt_q <= 1'b0;
            valid_q  <= 1'b0;
        end else if (pipe_load) begin
            alu_q    <= ALU_in;
            wdata_q  <= wdata_in;
            pc_q     <= PC_in;
            wrreg_q  <= WrReg_in;
            memwrt_q <= MemWrt_in;
            readen_q <= readEn_in;
            regwrt_q <= RegWrt_in;
            valid_q  <= valid_in & ~halt_in;
        end else if (pipe_bubble) begin
            memwrt_q <= 1'b0;
            readen_q <= 1'b0;
            regwrt_q <= 1'b0;
            valid_q  <= 1'b0;
        end
    end

    assign ALU         = alu_q;
    assign writeData   = wdata_q;
    assign PC          = pc_q;
    assign WrReg       = wrreg_q;
    assign valid       = valid_q;
    assign MemWrt      = valid_q & memwrt_q;
    assign readEn      = valid_q & readen_q;
    assign RegWrt      = valid_q & regwrt_q;
    assign fwd_valid   = valid_q & regwrt_q & ~readen_q;
    assign load_hazard = valid_q & regwrt_q & readen_q;
    assign fwd_reg     = wrreg_q;
    assign fwd_data    = alu_q;
    assign halt_stall  = (state_q != S_RUN);
    assign dump_req    = (state_q == S_DUMP);
    assign halted      = (state_q == S_HALTED);
    assign dbg_state   = state_q;

endmodule
